// File: rtl/riscv_enc_pkg.sv
// Shared encodings for the RISC-V instruction encoder: format codes, major opcodes, FSM states.
// Includes the 12-bit immediate range helper used by the packer.
package riscv_enc_pkg;

    localparam logic [1:0] FMT_I = 2'b00;
    localparam logic [1:0] FMT_S = 2'b01;
    localparam logic [1:0] FMT_R = 2'b10;
    localparam logic [1:0] FMT_B = 2'b11;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } state_t;

    // True when the 64-bit immediate is representable as a signed 12-bit field.
    function automatic logic imm_fits12(input logic [63:0] imm);
        return imm[63:11] == {53{imm[11]}};
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: turns decoded fields into one 32-bit RISC-V word
// and reports whether the immediate fits the 12-bit field of the chosen format.
module instr_pack
    import riscv_enc_pkg::*;
(
    input  logic [1:0]  i_fmt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [63:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_in_range
);

    logic [11:0] w_imm12;
    logic        w_fits;

    assign w_imm12 = i_imm[11:0];
    assign w_fits  = imm_fits12(i_imm);

    always_comb begin
        o_word     = '0;
        o_in_range = 1'b1;
        case (i_fmt)
            FMT_I: begin
                o_word     = {w_imm12, i_rs1, i_funct3, i_rd, OP_LOAD};
                o_in_range = w_fits;
            end
            FMT_S: begin
                o_word     = {w_imm12[11:5], i_rs2, i_rs1, i_funct3, w_imm12[4:0], OP_STORE};
                o_in_range = w_fits;
            end
            FMT_R: begin
                o_word     = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, OP_ALU};
                o_in_range = 1'b1;
            end
            default: begin
                // B immediate is in halfword units; layout mirrors the core's SB extraction.
                o_word     = {w_imm12[11], w_imm12[9:4], i_rs2, i_rs1, i_funct3,
                              w_imm12[3:0], w_imm12[10], OP_BRANCH};
                o_in_range = w_fits;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder/loader: packs requests and writes them to consecutive words.
// Optional IMM_RANGE_CHECK_EN drops out-of-range immediates and raises a sticky imm_err.
module instr_encoder
    import riscv_enc_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [63:0]       imm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [8:0]        word_count,
    output logic              full,
    output logic              imm_err
);

`ifdef IMM_RANGE_CHECK_EN
    localparam logic IMM_CHECK = 1'b1;
`else
    localparam logic IMM_CHECK = 1'b0;
`endif

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [8:0]        r_count;
    logic              r_err;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;

    logic [31:0]       w_word;
    logic              w_in_range;
    logic              w_xfer;
    logic              w_write;
    logic              w_last;
    logic [ADDR_W-1:0] w_offset;
    logic [ADDR_W-1:0] w_base_aligned;

    instr_pack u_pack (
        .i_fmt      (fmt),
        .i_rd       (rd),
        .i_rs1      (rs1),
        .i_rs2      (rs2),
        .i_funct3   (funct3),
        .i_funct7   (funct7),
        .i_imm      (imm),
        .o_word     (w_word),
        .o_in_range (w_in_range)
    );

    assign in_ready       = (r_state == RUN) && !start;
    assign w_xfer         = in_valid && in_ready;
    assign w_write        = w_xfer && (w_in_range || !IMM_CHECK);
    assign w_last         = (r_count == 9'(DEPTH - 1));
    assign w_offset       = ADDR_W'({r_count, 2'b00});
    assign w_base_aligned = base_addr & ~ADDR_W'(3);

    // A start on a cycle that is presenting a write leaves that write untouched;
    // the reload only affects the next accepted request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_base    <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (start) begin
                r_state <= RUN;
                r_base  <= w_base_aligned;
                r_count <= '0;
                r_err   <= 1'b0;
            end else if (w_xfer) begin
                if (w_write) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_base + w_offset;
                    r_wr_data <= w_word;
                    r_count   <= r_count + 9'd1;
                    if (w_last) begin
                        r_state <= FULL;
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign word_count = r_count;
    assign full       = (r_state == FULL);
    assign imm_err    = IMM_CHECK & r_err;

endmodule
